// File: rtl/amns_mm_scheduler.sv
// amns_mm_scheduler
// Round-robin front end that shares one polynomial FIOS Montgomery multiplier
// datapath between NREQ requesters. The winner's operands are latched into
// local rotate/shift registers that the datapath walks word by word; the
// result is returned to the originating requester with a valid/ready handshake.
//
// Optional feature: define AMNS_SCHED_WATCHDOG_EN to abort a job whose
// datapath has not signalled done within TIMEOUT BUSY cycles. The aborted
// job still gets a response, with rsp_err_o=1 and a zero result.
module amns_mm_scheduler #(
    parameter int NREQ     = 2,
    parameter int s        = 5,
    parameter int N        = 5,
    parameter int W        = 17,
    parameter int TIMEOUT  = 4096,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*s*W-1:0]   req_A_i,
    input  logic [NREQ*N*W-1:0]   req_B_i,
    input  logic [NREQ*s*W-1:0]   req_M_prime_0_i,
    input  logic [NREQ*N*W-1:0]   req_M_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [N*W-1:0]        rsp_res_o,
    output logic                  rsp_err_o,
    output logic                  fios_start_o,
    output logic [s*W-1:0]        fios_A_o,
    output logic [N*W-1:0]        fios_B_o,
    output logic [W-1:0]          fios_M_prime_0_o,
    output logic [W-1:0]          fios_M_o,
    input  logic                  fios_A_rot_i,
    input  logic                  fios_M_prime_0_rot_i,
    input  logic                  fios_B_shift_i,
    input  logic                  fios_M_shift_i,
    input  logic                  fios_done_i,
    input  logic [N*W-1:0]        fios_res_i
);

    localparam int SW = s * W;
    localparam int NW = N * W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [SW-1:0]   a_r;
    logic [SW-1:0]   mp_r;
    logic [NW-1:0]   b_r;
    logic [NW-1:0]   m_r;
    logic [NW-1:0]   res_r;
    logic            start_r;
    logic            valid_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [NREQ-1:0] grant_oh_s;
    logic [SW-1:0]   sel_a_s;
    logic [SW-1:0]   sel_mp_s;
    logic [NW-1:0]   sel_b_s;
    logic [NW-1:0]   sel_m_s;

`ifdef AMNS_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]  wd_cnt_r;
    logic            err_r;
`endif

    // Round-robin search: first valid requester at or above rr_ptr_r, wrapping.
    always_comb begin
        logic [IDW-1:0] cand_v;
        cand_v        = '0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_v = IDW'((int'(rr_ptr_r) + i) % NREQ);
            if (!grant_found_s && req_valid_i[cand_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_v;
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // One-hot grant, next round-robin pointer and operand slice selection.
    always_comb begin
        grant_oh_s = '0;
        sel_a_s    = '0;
        sel_mp_s   = '0;
        sel_b_s    = '0;
        sel_m_s    = '0;
        if (grant_found_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
        if (int'(grant_idx_s) >= NREQ - 1) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + IDW'(1);
        end
        for (int r = 0; r < NREQ; r++) begin
            if (IDW'(r) == grant_idx_s) begin
                sel_a_s  = req_A_i[r*SW +: SW];
                sel_mp_s = req_M_prime_0_i[r*SW +: SW];
                sel_b_s  = req_B_i[r*NW +: NW];
                sel_m_s  = req_M_i[r*NW +: NW];
            end else begin
                sel_a_s  = sel_a_s;
                sel_mp_s = sel_mp_s;
                sel_b_s  = sel_b_s;
                sel_m_s  = sel_m_s;
            end
        end
    end

    // Main control: accept, start pulse, strobe service, result capture, response.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= '0;
            id_r     <= '0;
            a_r      <= '0;
            mp_r     <= '0;
            b_r      <= '0;
            m_r      <= '0;
            res_r    <= '0;
            start_r  <= 1'b0;
            valid_r  <= 1'b0;
`ifdef AMNS_SCHED_WATCHDOG_EN
            wd_cnt_r <= '0;
            err_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        a_r      <= sel_a_s;
                        mp_r     <= sel_mp_s;
                        b_r      <= sel_b_s;
                        m_r      <= sel_m_s;
                        id_r     <= grant_idx_s;
                        rr_ptr_r <= next_ptr_s;
                        start_r  <= 1'b1;
                        state_r  <= ST_START;
`ifdef AMNS_SCHED_WATCHDOG_EN
                        err_r    <= 1'b0;
`endif
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_START: begin
                    start_r  <= 1'b0;
                    state_r  <= ST_BUSY;
`ifdef AMNS_SCHED_WATCHDOG_EN
                    wd_cnt_r <= '0;
`endif
                end
                ST_BUSY: begin
                    // Strobes apply even in the cycle that carries done.
                    if (fios_A_rot_i) begin
                        a_r <= {a_r[W-1:0], a_r[SW-1:W]};
                    end else begin
                        a_r <= a_r;
                    end
                    if (fios_M_prime_0_rot_i) begin
                        mp_r <= {mp_r[W-1:0], mp_r[SW-1:W]};
                    end else begin
                        mp_r <= mp_r;
                    end
                    if (fios_B_shift_i) begin
                        b_r <= {{W{1'b0}}, b_r[NW-1:W]};
                    end else begin
                        b_r <= b_r;
                    end
                    if (fios_M_shift_i) begin
                        m_r <= {{W{1'b0}}, m_r[NW-1:W]};
                    end else begin
                        m_r <= m_r;
                    end
                    if (fios_done_i) begin
                        res_r   <= fios_res_i;
                        valid_r <= 1'b1;
                        state_r <= ST_RESP;
                    end
`ifdef AMNS_SCHED_WATCHDOG_EN
                    else if (wd_cnt_r == WDW'(TIMEOUT - 1)) begin
                        res_r   <= '0;
                        err_r   <= 1'b1;
                        valid_r <= 1'b1;
                        state_r <= ST_RESP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WDW'(1);
                        state_r  <= ST_BUSY;
                    end
`else
                    else begin
                        state_r <= ST_BUSY;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o      = (state_r == ST_IDLE) ? grant_oh_s : '0;
    assign rsp_valid_o      = valid_r;
    assign rsp_id_o         = id_r;
    assign rsp_res_o        = res_r;
    assign fios_start_o     = start_r;
    assign fios_A_o         = a_r;
    assign fios_B_o         = b_r;
    assign fios_M_prime_0_o = mp_r[W-1:0];
    assign fios_M_o         = m_r[W-1:0];
`ifdef AMNS_SCHED_WATCHDOG_EN
    assign rsp_err_o        = err_r;
`else
    assign rsp_err_o        = 1'b0;
`endif

endmodule
